program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter ADDR_W, 4, program ROM address width; the PC wraps at 2^ADDR_W.
REQ-002 Parameter DATA_W, 16, instruction, register and output width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run  input  1  level; sequencer fetches only while high.
REQ-006 rom_addr  output  ADDR_W  ROM address; equals PC.
REQ-007 instruction  input  DATA_W  combinational ROM data for rom_addr.
REQ-008 out_data  output  DATA_W  value presented by OUT.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 busy  output  1  high in FETCH, EXEC and OUT_WAIT.
REQ-012 halted  output  1  high in HALT.

Function
REQ-013 Encoding: [15:12] opcode; [11:9] rd; [8:6] rs; [7:0] imm8, zero-extended.
REQ-014 Opcodes: 0000 NOP; 0001 ADDI rd+=imm8; 0010 ADD rd+=rs; 0011 SUB rd-=rs; 1110 HALT; 1111 OUT rd; all others execute as NOP.
REQ-015 The register file has 8 registers of DATA_W bits; r0 reads as zero and writes to r0 are discarded.
REQ-016 Arithmetic is modulo 2^DATA_W; carry and borrow are dropped; no flags are kept.
REQ-017 FSM states: IDLE, FETCH, EXEC, OUT_WAIT, HALT.
REQ-018 IDLE: if run=1, go to FETCH; otherwise stay in IDLE.
REQ-019 FETCH: latch instruction into IR; opcode OUT -> OUT_WAIT, HALT -> HALT, else -> EXEC.
REQ-020 EXEC: write the ALU result to rd for ADDI/ADD/SUB and increment PC; then go to FETCH if run=1, else to IDLE.
REQ-021 OUT_WAIT: out_valid=1 and out_data=reg[rd], held stable until a transfer occurs.
REQ-022 Transfer: out_valid and out_ready both high on the same edge; then increment PC and go to FETCH if run=1, else to IDLE.
REQ-023 OUT_WAIT is never abandoned because run falls; the pause takes effect only after the transfer.
REQ-024 An out_ready pulse while out_valid=0 has no effect.
REQ-025 Latency: non-OUT instructions take 2 cycles; OUT takes 1 cycle plus its handshake wait.
REQ-026 PC increments modulo 2^ADDR_W; the address after 15 is 0, with no halt or error.
REQ-027 HALT freezes the PC at the HALT address, keeps busy=0 and halted=1, and is left only by reset.
REQ-028 Register contents are retained across IDLE pauses.

Reset
REQ-029 While reset=1: state=IDLE, PC=0, IR=0, all registers=0, out_valid=0, out_data=0, busy=0, halted=0.
REQ-030 Reset overrides every state, including mid-OUT_WAIT; out_valid is low in the cycle after the reset edge.

Structure
REQ-031 A shared package holds the opcode constants, the field bit positions, and the FSM state encoding.
REQ-032 The register file plus ALU form one sub-module, seq_datapath; the FSM and PC remain in program_sequencer.

Verification
REQ-033 Reset test: assert reset with run=1 -> rom_addr=0, out_valid=0, busy=0, halted=0.
REQ-034 Program test: ROM {ADDI r1,15; ADDI r2,15; ADD r1,r2; OUT r1}, out_ready=1, run raised -> out_valid=1 with out_data=0x001E after 8 edges, for exactly one cycle.
REQ-035 Backpressure test: same program with out_ready=0 for 5 cycles -> out_valid stays high, out_data stays 0x001E, rom_addr stays 3; after release, rom_addr=4.
REQ-036 Wrap-and-pause test: 16 NOPs -> rom_addr goes 15 to 0 after 32 edges; dropping run -> IDLE, rom_addr frozen; raising run resumes from that address.
REQ-037 Arithmetic test: {ADDI r1,1; ADDI r2,2; SUB r1,r2; OUT r1; ADDI r0,5; OUT r0} -> outputs 0xFFFF then 0x0000.
REQ-038 HALT/reset test: HALT at address 6 -> halted=1 and rom_addr=6 held indefinitely; reset during OUT_WAIT -> out_valid=0 and rom_addr=0 on the next edge.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// Shared opcodes, instruction field positions and FSM state encoding
// for the program sequencer and its datapath.
package program_sequencer_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_HALT = 4'he;
    localparam logic [3:0] OP_OUT  = 4'hf;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_OUT_WAIT,
        S_HALT
    } state_t;

endpackage

// File: rtl/seq_datapath.sv
// Eight-entry register file (r0 hard zero) plus the ADDI/ADD/SUB ALU.
// Writes happen only on cycles where exec_en is high.
module seq_datapath
    import program_sequencer_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exec_en,
    input  logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] rd_value
);

    logic [DATA_W-1:0] regs [8];
    logic [3:0]        opcode;
    logic [2:0]        rd;
    logic [2:0]        rs;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rs_value;
    logic [DATA_W-1:0] result;
    logic              wr;

    assign opcode   = ir[OP_MSB:OP_LSB];
    assign rd       = ir[RD_MSB:RD_LSB];
    assign rs       = ir[RS_MSB:RS_LSB];
    assign imm      = {{(DATA_W-8){1'b0}}, ir[IMM_MSB:IMM_LSB]};
    // regs[0] is never written, so r0 reads zero without a mux
    assign rd_value = regs[rd];
    assign rs_value = regs[rs];

    always_comb begin
        result = rd_value;
        wr     = 1'b0;
        case (opcode)
            OP_ADDI: begin
                result = rd_value + imm;
                wr     = 1'b1;
            end
            OP_ADD: begin
                result = rd_value + rs_value;
                wr     = 1'b1;
            end
            OP_SUB: begin
                result = rd_value - rs_value;
                wr     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (exec_en && wr && (rd != 3'd0)) begin
            regs[rd] <= result;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Fetch/execute sequencer: FSM, PC and IR, with a valid/ready OUT port.
// Register file and ALU live in seq_datapath.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              halted
);

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_n;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] rd_value;
    logic [3:0]        fetch_op;

    assign fetch_op = instruction[OP_MSB:OP_LSB];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            if (state == S_FETCH) begin
                ir <= instruction;
            end
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        case (state)
            S_IDLE: begin
                if (run) state_n = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_op == OP_OUT)       state_n = S_OUT_WAIT;
                else if (fetch_op == OP_HALT) state_n = S_HALT;
                else                          state_n = S_EXEC;
            end
            S_EXEC: begin
                pc_n    = pc + 1'b1;
                state_n = run ? S_FETCH : S_IDLE;
            end
            // run is ignored until the word has been taken
            S_OUT_WAIT: begin
                if (out_ready) begin
                    pc_n    = pc + 1'b1;
                    state_n = run ? S_FETCH : S_IDLE;
                end
            end
            S_HALT:  state_n = S_HALT;
            default: state_n = S_IDLE;
        endcase
    end

    seq_datapath #(
        .DATA_W (DATA_W)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .exec_en  (state == S_EXEC),
        .ir       (ir),
        .rd_value (rd_value)
    );

    assign rom_addr  = pc;
    assign out_valid = (state == S_OUT_WAIT);
    assign out_data  = out_valid ? rd_value : '0;
    assign busy      = (state == S_FETCH) || (state == S_EXEC)
                    || (state == S_OUT_WAIT);
    assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer.
// Outputs are sampled 1ns after each rising edge.
module tb_program_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic [3:0]  rom_addr;
    logic [15:0] instruction;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        halted;

    logic [15:0] rom [16];
    int          checks;
    int          failures;

    assign instruction = rom[rom_addr];

    program_sequencer #(
        .ADDR_W (4),
        .DATA_W (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .rom_addr    (rom_addr),
        .instruction (instruction),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    endtask

    task automatic load_sum_prog();
        clear_rom();
        rom[0] = 16'h120f; // ADDI r1,15
        rom[1] = 16'h140f; // ADDI r2,15
        rom[2] = 16'h2280; // ADD  r1,r2
        rom[3] = 16'hf200; // OUT  r1
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        run       = 1'b1;
        out_ready = 1'b0;
        clear_rom();

        // reset held with run high
        tick(2);
        check("rst_addr", rom_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_data", out_data, 0);

        // sum program, consumer always ready
        load_sum_prog();
        out_ready = 1'b1;
        do_reset();
        tick(7);
        check("prog_e7_valid", out_valid, 0);
        check("prog_e7_addr", rom_addr, 3);
        tick(1);
        check("prog_e8_valid", out_valid, 1);
        check("prog_e8_data", out_data, 16'h001e);
        tick(1);
        check("prog_e9_valid", out_valid, 0);
        check("prog_e9_addr", rom_addr, 4);

        // backpressure, run dropped mid-wait
        out_ready = 1'b0;
        do_reset();
        tick(8);
        check("bp_valid0", out_valid, 1);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 16'h001e);
            check("bp_addr", rom_addr, 3);
        end
        out_ready = 1'b1;
        tick(1);
        check("bp_rel_valid", out_valid, 0);
        check("bp_rel_addr", rom_addr, 4);
        check("bp_rel_busy", busy, 0);
        tick(2);
        check("bp_idle_addr", rom_addr, 4);
        check("bp_idle_busy", busy, 0);

        // wrap and pause over 16 NOPs
        clear_rom();
        run       = 1'b1;
        out_ready = 1'b0;
        do_reset();
        tick(1);
        check("wrap_busy", busy, 1);
        check("wrap_addr0", rom_addr, 0);
        tick(30);
        check("wrap_addr15", rom_addr, 15);
        tick(2);
        check("wrap_addr_back0", rom_addr, 0);
        run = 1'b0;
        tick(2);
        check("pause_busy", busy, 0);
        check("pause_addr", rom_addr, 1);
        tick(3);
        check("pause_hold_addr", rom_addr, 1);
        check("pause_hold_busy", busy, 0);
        run = 1'b1;
        tick(1);
        check("resume_busy", busy, 1);
        check("resume_addr", rom_addr, 1);
        tick(2);
        check("resume_next", rom_addr, 2);

        // modular subtract and r0 write discard
        clear_rom();
        rom[0] = 16'h1201; // ADDI r1,1
        rom[1] = 16'h1402; // ADDI r2,2
        rom[2] = 16'h3280; // SUB  r1,r2
        rom[3] = 16'hf200; // OUT  r1
        rom[4] = 16'h1005; // ADDI r0,5
        rom[5] = 16'hf000; // OUT  r0
        out_ready = 1'b1;
        do_reset();
        tick(8);
        check("sub_valid", out_valid, 1);
        check("sub_data", out_data, 16'hffff);
        tick(4);
        check("r0_valid", out_valid, 1);
        check("r0_data", out_data, 16'h0000);
        check("r0_addr", rom_addr, 5);

        // HALT at address 6
        clear_rom();
        rom[6] = 16'he000;
        do_reset();
        tick(14);
        check("halt_halted", halted, 1);
        check("halt_busy", busy, 0);
        check("halt_addr", rom_addr, 6);
        run = 1'b0;
        tick(10);
        check("halt_hold", halted, 1);
        check("halt_hold_addr", rom_addr, 6);

        // reset while waiting on OUT
        load_sum_prog();
        run       = 1'b1;
        out_ready = 1'b0;
        do_reset();
        check("hrst_halted", halted, 0);
        tick(8);
        check("orst_pre_valid", out_valid, 1);
        reset = 1'b1;
        tick(1);
        check("orst_valid", out_valid, 0);
        check("orst_addr", rom_addr, 0);
        check("orst_busy", busy, 0);
        check("orst_data", out_data, 0);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
